// File: rtl/cpu_core.sv
// cpu_core: minimal 8-bit 6502-subset CPU.
// It drives one 16-bit address / 8-bit data bus, and read data is combinational.
// Binary arithmetic only. There is no decimal mode, no interrupts and no stack.
module cpu_core #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    output logic [15:0] o_Addr,
    input  logic [7:0]  i_Data,
    output logic [7:0]  o_Data,
    output logic        o_We,
    output logic [7:0]  o_A,
    output logic [7:0]  o_X,
    output logic [15:0] o_PC,
    output logic [3:0]  o_Flags,
    output logic        o_Halted
);

    typedef enum logic [2:0] {
        VEC_LO, VEC_HI, FETCH, OP1, OP2, MEM, EXEC, HALT
    } state_t;

    localparam logic [7:0] OP_TAX     = 8'hAA;
    localparam logic [7:0] OP_INX     = 8'hE8;
    localparam logic [7:0] OP_CLC     = 8'h18;
    localparam logic [7:0] OP_SEC     = 8'h38;
    localparam logic [7:0] OP_STP     = 8'hDB;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDX_IMM = 8'hA2;
    localparam logic [7:0] OP_ADC_IMM = 8'h69;
    localparam logic [7:0] OP_BNE     = 8'hD0;
    localparam logic [7:0] OP_BEQ     = 8'hF0;
    localparam logic [7:0] OP_JMP     = 8'h4C;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;

    state_t      state, state_next;
    logic [7:0]  a, x, ir, lo, hi;
    logic [15:0] pc;
    logic        flag_n, flag_v, flag_z, flag_c;
    logic [8:0]  sum;
    logic [7:0]  x_inc;
    logic [15:0] branch_target;
    logic        branch_taken;

    // Returns 1 for opcodes that carry an operand byte. Unknown opcodes are 1-byte NOPs.
    function automatic logic has_operand(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_LDX_IMM, OP_ADC_IMM, OP_BNE, OP_BEQ,
            OP_JMP, OP_LDA_ABS, OP_STA_ABS: has_operand = 1'b1;
            default:                        has_operand = 1'b0;
        endcase
    endfunction

    assign sum           = {1'b0, a} + {1'b0, i_Data} + {8'd0, flag_c};
    assign x_inc         = x + 8'd1;
    // In OP1, pc already points at the operand byte.
    // The branch offset is relative to the byte that follows the operand.
    assign branch_target = pc + 16'd1 + {{8{i_Data[7]}}, i_Data};
    assign branch_taken  = ((ir == OP_BNE) && !flag_z) || ((ir == OP_BEQ) && flag_z);

    assign o_A      = a;
    assign o_X      = x;
    assign o_PC     = pc;
    assign o_Flags  = {flag_n, flag_v, flag_z, flag_c};
    assign o_Halted = (state == HALT);

    // State register. Reset restarts the reset-vector fetch.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state <= VEC_LO;
        else         state <= state_next;
    end

    // Next-state decode and bus outputs. A write is only driven in the STA memory cycle.
    always_comb begin
        state_next = state;
        o_Addr     = pc;
        o_We       = 1'b0;
        o_Data     = '0;
        case (state)
            VEC_LO: begin
                o_Addr     = RESET_VECTOR;
                state_next = VEC_HI;
            end
            VEC_HI: begin
                o_Addr     = RESET_VECTOR + 16'd1;
                state_next = FETCH;
            end
            FETCH: state_next = has_operand(i_Data) ? OP1 : EXEC;
            OP1: begin
                case (ir)
                    OP_JMP, OP_LDA_ABS, OP_STA_ABS: state_next = OP2;
                    default:                        state_next = FETCH;
                endcase
            end
            OP2: state_next = (ir == OP_JMP) ? FETCH : MEM;
            MEM: begin
                o_Addr     = {hi, lo};
                state_next = FETCH;
                if (ir == OP_STA_ABS) begin
                    o_We   = 1'b1;
                    o_Data = a;
                end
            end
            EXEC: state_next = (ir == OP_STP) ? HALT : FETCH;
            HALT: state_next = HALT;
        endcase
    end

    // Architectural registers and operand latches.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            a      <= '0;
            x      <= '0;
            pc     <= '0;
            ir     <= '0;
            lo     <= '0;
            hi     <= '0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            case (state)
                VEC_LO: pc[7:0]  <= i_Data;
                VEC_HI: pc[15:8] <= i_Data;
                FETCH: begin
                    ir <= i_Data;
                    pc <= pc + 16'd1;
                end
                OP1: begin
                    pc <= pc + 16'd1;
                    case (ir)
                        OP_LDA_IMM: begin
                            a      <= i_Data;
                            flag_n <= i_Data[7];
                            flag_z <= (i_Data == 8'd0);
                        end
                        OP_LDX_IMM: begin
                            x      <= i_Data;
                            flag_n <= i_Data[7];
                            flag_z <= (i_Data == 8'd0);
                        end
                        OP_ADC_IMM: begin
                            a      <= sum[7:0];
                            flag_c <= sum[8];
                            flag_v <= (a[7] == i_Data[7]) && (sum[7] != a[7]);
                            flag_n <= sum[7];
                            flag_z <= (sum[7:0] == 8'd0);
                        end
                        OP_BNE, OP_BEQ: begin
                            if (branch_taken) pc <= branch_target;
                        end
                        OP_JMP, OP_LDA_ABS, OP_STA_ABS: lo <= i_Data;
                        default: ;
                    endcase
                end
                OP2: begin
                    if (ir == OP_JMP) begin
                        pc <= {i_Data, lo};
                    end else begin
                        hi <= i_Data;
                        pc <= pc + 16'd1;
                    end
                end
                MEM: begin
                    if (ir == OP_LDA_ABS) begin
                        a      <= i_Data;
                        flag_n <= i_Data[7];
                        flag_z <= (i_Data == 8'd0);
                    end
                end
                EXEC: begin
                    case (ir)
                        OP_TAX: begin
                            x      <= a;
                            flag_n <= a[7];
                            flag_z <= (a == 8'd0);
                        end
                        OP_INX: begin
                            x      <= x_inc;
                            flag_n <= x_inc[7];
                            flag_z <= (x_inc == 8'd0);
                        end
                        OP_CLC:  flag_c <= 1'b0;
                        OP_SEC:  flag_c <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_core.sv
// Testbench for cpu_core.
// An instruction-level model builds the expected per-cycle bus and register trace.
// The DUT is then checked against that trace on every cycle.
module tb_cpu_core;

    localparam logic [15:0] RV = 16'hFFFC;

    logic        clk, rst;
    logic [15:0] addr, pc;
    logic [7:0]  rdata, wdata, a, x;
    logic        we, halted;
    logic [3:0]  flags;

    logic [7:0] mem  [0:65535];
    logic [7:0] mmem [0:65535];

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
        logic [7:0]  a;
        logic [7:0]  x;
        logic [15:0] pc;
        logic [3:0]  flags;
        logic        halted;
    } exp_t;

    exp_t exp_q [$];

    int          tests, fails;
    bit          checking;
    int          cyc, we_count, watch_count, halt_cyc;
    logic [15:0] watch_addr, pc_c2, addr_c2;

    logic [7:0] op_tab [14] = '{8'hA9, 8'hA2, 8'h69, 8'hD0, 8'hF0, 8'h4C, 8'hAD,
                                8'h8D, 8'hAA, 8'hE8, 8'h18, 8'h38, 8'hEA, 8'hDB};

    cpu_core #(.RESET_VECTOR(RV)) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .o_Addr  (addr),
        .i_Data  (rdata),
        .o_Data  (wdata),
        .o_We    (we),
        .o_A     (a),
        .o_X     (x),
        .o_PC    (pc),
        .o_Flags (flags),
        .o_Halted(halted)
    );

    assign rdata = mem[addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus write port of the bench memory.
    initial begin
        forever begin
            @(posedge clk);
            if (we === 1'b1) mem[addr] = wdata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic int sval(input logic [7:0] b);
        return (b >= 8'd128) ? int'(b) - 256 : int'(b);
    endfunction

    task automatic emit(input logic [15:0] ad, input logic w, input logic [7:0] ra,
                        input logic [7:0] rx, input logic [15:0] rpc,
                        input logic [3:0] fl, input logic h);
        exp_t e;
        e.addr   = ad;
        e.we     = w;
        e.data   = w ? ra : 8'h00;
        e.a      = ra;
        e.x      = rx;
        e.pc     = rpc;
        e.flags  = fl;
        e.halted = h;
        exp_q.push_back(e);
    endtask

    // Instruction-level reference. Every instruction shows PC+k on the bus in its k-th cycle.
    // The 4th cycle of an absolute access is the exception: it shows the operand address.
    // Results become visible after the last cycle of the instruction.
    task automatic build_trace(input int unsigned max_instr, input int unsigned halt_cycles);
        logic [7:0]  ra, rx, op, b1, b2;
        logic [15:0] rpc, ea;
        logic        fn, fv, fz, fc;
        bit          stopped;
        int          s, ss;
        int unsigned ncyc;
        exp_q.delete();
        ra = 0; rx = 0; rpc = 0; fn = 0; fv = 0; fz = 0; fc = 0; stopped = 0;
        emit(RV, 1'b0, ra, rx, rpc, 4'h0, 1'b0);
        rpc = {8'h00, mmem[RV]};
        emit(RV + 16'd1, 1'b0, ra, rx, rpc, 4'h0, 1'b0);
        rpc = {mmem[RV + 16'd1], mmem[RV]};
        for (int unsigned i = 0; i < max_instr && !stopped; i++) begin
            op = mmem[rpc];
            b1 = mmem[rpc + 16'd1];
            b2 = mmem[rpc + 16'd2];
            ea = {b2, b1};
            case (op)
                8'h4C:        ncyc = 3;
                8'hAD, 8'h8D: ncyc = 4;
                default:      ncyc = 2;
            endcase
            for (int unsigned k = 0; k < ncyc; k++)
                emit((k == 3) ? ea : rpc + 16'(k), (k == 3) && (op == 8'h8D),
                     ra, rx, rpc + 16'(k), {fn, fv, fz, fc}, 1'b0);
            case (op)
                8'hAA: begin rx = ra; fn = rx[7]; fz = (rx == 0); rpc = rpc + 16'd1; end
                8'hE8: begin rx = 8'((int'(rx) + 1) % 256); fn = rx[7]; fz = (rx == 0); rpc = rpc + 16'd1; end
                8'h18: begin fc = 0; rpc = rpc + 16'd1; end
                8'h38: begin fc = 1; rpc = rpc + 16'd1; end
                8'hDB: begin stopped = 1; rpc = rpc + 16'd1; end
                8'hA9: begin ra = b1; fn = ra[7]; fz = (ra == 0); rpc = rpc + 16'd2; end
                8'hA2: begin rx = b1; fn = rx[7]; fz = (rx == 0); rpc = rpc + 16'd2; end
                8'h69: begin
                    s  = int'(ra) + int'(b1) + int'(fc);
                    ss = sval(ra) + sval(b1) + int'(fc);
                    fv = (ss > 127) || (ss < -128);
                    fc = (s > 255);
                    ra = 8'(s % 256);
                    fn = ra[7]; fz = (ra == 0);
                    rpc = rpc + 16'd2;
                end
                8'hD0, 8'hF0: begin
                    if ((op == 8'hD0) != fz) rpc = 16'((int'(rpc) + 2 + sval(b1)) % 65536);
                    else                     rpc = rpc + 16'd2;
                end
                8'h4C: rpc = ea;
                8'hAD: begin ra = mmem[ea]; fn = ra[7]; fz = (ra == 0); rpc = rpc + 16'd3; end
                8'h8D: begin mmem[ea] = ra; rpc = rpc + 16'd3; end
                default: rpc = rpc + 16'd1;
            endcase
        end
        if (stopped)
            for (int unsigned k = 0; k < halt_cycles; k++)
                emit(rpc, 1'b0, ra, rx, rpc, {fn, fv, fz, fc}, 1'b1);
    endtask

    // Per-cycle comparison against the model trace.
    initial begin : compare
        exp_t e, act;
        forever begin
            @(negedge clk);
            if (checking) begin
                act = {addr, we, we ? wdata : 8'h00, a, x, pc, flags, halted};
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("cycle%0d", cyc), 64'(act), 64'(e));
                end
                if (cyc == 2) begin pc_c2 = pc; addr_c2 = addr; end
                if (we === 1'b1) we_count++;
                if (addr == watch_addr) watch_count++;
                if (halted === 1'b1 && halt_cyc < 0) halt_cyc = cyc;
                cyc++;
                if (exp_q.size() == 0) checking = 0;
            end
        end
    end

    task automatic fill_both(input logic [7:0] v);
        for (int i = 0; i < 65536; i++) begin mem[i] = v; mmem[i] = v; end
    endtask

    task automatic poke(input logic [15:0] ad, input logic [7:0] v);
        mem[ad] = v; mmem[ad] = v;
    endtask

    task automatic load_prog(input logic [15:0] base, input logic [47:0] bytes, input int unsigned len);
        for (int unsigned i = 0; i < len; i++)
            poke(base + 16'(i), bytes[8 * (len - 1 - i) +: 8]);
    endtask

    task automatic setup_directed(input logic [47:0] bytes, input int unsigned len);
        fill_both(8'h00);
        poke(RV, 8'h00);
        poke(RV + 16'd1, 8'h80);
        load_prog(16'h8000, bytes, len);
    endtask

    task automatic run_program(input int unsigned reset_cycles, input int unsigned max_instr,
                               input int unsigned halt_cycles);
        int unsigned n;
        #($urandom_range(1, 8));
        rst = 1'b1;
        #1;
        chk("async_reset", {addr, we}, {RV, 1'b0});
        repeat (reset_cycles) @(posedge clk);
        #1;
        chk("reset_state", {addr, we, wdata, a, x, pc, flags, halted},
            {RV, 1'b0, 8'h00, 8'h00, 8'h00, 16'h0000, 4'h0, 1'b0});
        build_trace(max_instr, halt_cycles);
        cyc = 0; we_count = 0; watch_count = 0; halt_cyc = -1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1;
        n = 0;
        while (checking && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (checking) begin
            tests++;
            fails++;
            $display("FAIL trace_timeout: %0d entries left, expected 0", exp_q.size());
            checking = 0;
            exp_q.delete();
        end
    endtask

    initial begin
        int found;
        logic [7:0] b;
        tests = 0; fails = 0; checking = 0;
        rst = 1'b0;
        watch_addr = 16'h0000;
        #3;

        // Reset vector, then load/store and halt.
        setup_directed(48'hA9_42_8D_00_02_DB, 6);
        watch_addr = 16'h0200;
        run_program(10, 20, 4);
        chk("vec_pc", pc_c2, 16'h8000);
        chk("vec_addr", addr_c2, 16'h8000);
        chk("ls_a", a, 8'h42);
        chk("ls_flags", flags, 4'h0);
        chk("ls_mem", mem[16'h0200], 8'h42);
        chk("ls_we_cycles", we_count, 1);
        chk("ls_halt_cycle", halt_cyc, 10);
        chk("ls_halted", halted, 1'b1);

        // ADC overflow case.
        setup_directed(48'h18_A9_7F_69_01_DB, 6);
        run_program(3, 20, 3);
        chk("adc_ov_a", a, 8'h80);
        chk("adc_ov_flags", flags, 4'hC);

        // ADC carry case.
        setup_directed(48'h38_A9_FF_69_00_DB, 6);
        run_program(3, 20, 3);
        chk("adc_c_a", a, 8'h00);
        chk("adc_c_flags", flags, 4'h3);

        // Backward BNE loop.
        setup_directed(48'hA2_FD_E8_D0_FD_DB, 6);
        watch_addr = 16'h8002;
        run_program(2, 40, 3);
        chk("loop_x", x, 8'h00);
        chk("loop_flags", flags, 4'h2);
        chk("loop_inx_count", watch_count, 3);
        chk("loop_halt_cycle", halt_cyc, 18);
        chk("loop_pc", pc, 16'h8006);

        // JMP then LDA abs.
        setup_directed(48'h4C_10_80, 3);
        load_prog(16'h8010, 48'hAD_34_12_DB, 4);
        poke(16'h1234, 8'hA5);
        watch_addr = 16'h8013;
        run_program(2, 20, 3);
        chk("jmp_reach_8013", watch_count, 1);
        chk("jmp_lda_a", a, 8'hA5);
        chk("jmp_lda_flags", flags, 4'h8);
        chk("jmp_pc", pc, 16'h8014);
        chk("jmp_halt_cycle", halt_cyc, 11);

        // Reset asserted during the STA memory cycle.
        setup_directed(48'hA9_42_8D_00_02_DB, 6);
        poke(16'h0200, 8'h11);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (we === 1'b1) found = 1;
        end
        chk("abort_we_seen", found, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_we", we, 1'b0);
        chk("abort_addr", addr, RV);
        chk("abort_regs", {a, x, pc, flags}, 36'h0);
        @(posedge clk);
        #1;
        chk("abort_nowrite", mem[16'h0200], 8'h11);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("restart_lo", addr, RV);
        @(negedge clk);
        chk("restart_hi", addr, RV + 16'd1);
        chk("restart_pcl", pc, 16'h0000);

        // Random programs over randomly filled memory.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 65536; i++) begin
                if ($urandom_range(0, 9) < 7) b = op_tab[$urandom_range(0, 13)];
                else                          b = 8'($urandom);
                mem[i] = b;
                mmem[i] = b;
            end
            watch_addr = 16'h0000;
            run_program($urandom_range(1, 4), 120, 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Minimal 8-bit 6502-subset CPU core. It is the compute block of the 6502 FPGA design.
- Drives a single 16-bit address / 8-bit data memory bus. Memory read data is combinational: i_Data is valid in the same cycle as o_Addr.
- Exposes architectural registers for debug and board LEDs.
- Binary arithmetic only; no decimal mode, interrupts or stack.

Parameters:
RESET_VECTOR, 16'hFFFC, address of the reset-vector low byte; the high byte is at RESET_VECTOR+1.

Ports:
i_Clk  in  1  system clock; all state changes on the rising edge
i_Reset  in  1  asynchronous, active-high reset
o_Addr  out  16  memory address
i_Data  in  8  memory read data, combinational from o_Addr
o_Data  out  8  memory write data
o_We  out  1  write strobe; the write occurs at the rising edge while high
o_A  out  8  accumulator
o_X  out  8  X register
o_PC  out  16  program counter
o_Flags  out  4  {N,V,Z,C}
o_Halted  out  1  high after the STP opcode executes

Behaviour:
- Reset (asynchronous, while i_Reset=1):
  - A=X=0, PC=0, flags=0, IR=0, o_We=0, o_Data=0, o_Halted=0.
  - State = VEC_LO; o_Addr=RESET_VECTOR.
- Reset release:
  - VEC_LO latches PCL from i_Data, then VEC_HI (o_Addr=RESET_VECTOR+1) latches PCH, then FETCH.
  - Reset asserted mid-instruction aborts it immediately; no partial write completes.
- States: VEC_LO, VEC_HI, FETCH, OP1, OP2, MEM, EXEC, HALT.
- FETCH: o_Addr=PC; IR<=i_Data; PC<=PC+1. Next state is EXEC for implied opcodes, otherwise OP1.
- Implied opcodes (2 cycles; EXEC with o_Addr=PC, no write):
  - TAX AA: X=A; sets N,Z.
  - INX E8: X=X+1 mod 256; sets N,Z.
  - CLC 18: C=0.
  - SEC 38: C=1.
  - NOP EA: no effect.
  - STP DB: enter HALT.
- Immediate opcodes (2 cycles; OP1 reads the operand at PC, PC+1, executes):
  - LDA# A9: A=imm; sets N,Z.
  - LDX# A2: X=imm; sets N,Z.
  - ADC# 69: {C,A}=A+imm+C. V=(A7==imm7)&&(res7!=A7). N,Z from the result.
- Branches (2 cycles; OP1 reads the signed offset, PC+1, then PC+=sign-extended offset if taken; the offset is relative to the byte after the operand):
  - BNE D0: taken if Z=0.
  - BEQ F0: taken if Z=1.
  - PC arithmetic wraps mod 65536.
- JMP abs 4C (3 cycles): OP1 latches the low byte, OP2 loads PC={i_Data,low}.
- LDA abs AD (4 cycles): OP1 low, OP2 high, MEM o_Addr=operand; A=i_Data; sets N,Z.
- STA abs 8D (4 cycles): MEM o_Addr=operand, o_Data=A, o_We=1 for exactly that cycle. No flags change.
- Undefined opcodes execute as 1-byte NOP (2 cycles).
- HALT: o_Halted=1; o_Addr holds PC; o_We=0; no register changes until reset.
- N = bit7 of the result; Z = (result==0).
- o_We=0 in every state except the STA MEM cycle.
- o_A, o_X, o_PC, o_Flags reflect the registers directly; updates are visible the cycle after the executing edge.

Test Plan:
- Reset vector: memory FFFC=00, FFFD=80; pulse i_Reset for 10 clocks, release -> after 2 cycles o_PC=8000 and the first FETCH has o_Addr=8000.
- Load/store: A9 42 8D 00 02 DB -> write at 0200 of 42 with o_We high for exactly one cycle; o_A=42; Z=0, N=0; o_Halted=1 after 2+4+2 cycles.
- ADC flags, overflow case: 18 A9 7F 69 01 -> A=80, N=1, V=1, C=0, Z=0.
- ADC flags, carry case: 38 A9 FF 69 00 -> A=00, C=1, Z=1.
- Loop: A2 FD E8 D0 FD DB -> INX runs 3 times; X=00, Z=1, halts; BNE taken twice and not taken once (backward branch with offset FD).
- JMP and LDA abs: 4C 10 80 at 8000, AD 34 12 at 8010, memory 1234=A5 -> PC reaches 8013, A=A5, N=1.
- Async reset during an STA MEM cycle -> o_We drops to 0 immediately; registers are cleared; reset-vector fetch restarts.
